// File: rtl/btp_pkg.sv
// Shared types and helpers for the branch target predictor.
// Purely declarative: no state and no timing of its own.
// No flow control: the package holds types and functions only.
package btp_pkg;

  // Control-flow class recorded per BTB entry.
  typedef enum logic [1:0] {
    CF_BR   = 2'd0,
    CF_JMP  = 2'd1,
    CF_CALL = 2'd2,
    CF_RET  = 2'd3
  } cf_type_e;

  // Per-entry payload. Valid and tag are held beside it in btb_table
  // because the tag width depends on the table depth.
  typedef struct packed {
    logic [29:0] target;
    cf_type_e    typ;
    logic [1:0]  ctr;
  } btb_entry_t;

  // Counter value on a fresh allocation.
  localparam logic [1:0] CTR_ALLOC_BR = 2'b10;
  localparam logic [1:0] CTR_STRONG   = 2'b11;

  // 2-bit saturating counter step.
  function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != 2'b11) nxt = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_table.sv
// BTB storage: valid/tag/payload array, two combinational read ports, one write port.
// Reads are zero latency and see pre-write contents; writes land on the rising edge.
// No backpressure: writes are always accepted; rst clears every valid bit at once.
module btb_table
  import btp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] a_rd_idx,
  output logic             a_rd_valid,
  output logic [TAG_W-1:0] a_rd_tag,
  output btb_entry_t       a_rd_entry,
  input  logic [IDX_W-1:0] b_rd_idx,
  output logic             b_rd_valid,
  output logic [TAG_W-1:0] b_rd_tag,
  output btb_entry_t       b_rd_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  btb_entry_t       wr_entry
);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q   [ENTRIES];
  logic [TAG_W-1:0]   tag_d   [ENTRIES];
  btb_entry_t         entry_q [ENTRIES];
  btb_entry_t         entry_d [ENTRIES];

  // Read ports look at the current (pre-write) contents.
  assign a_rd_valid = valid_q[a_rd_idx];
  assign a_rd_tag   = tag_q[a_rd_idx];
  assign a_rd_entry = entry_q[a_rd_idx];
  assign b_rd_valid = valid_q[b_rd_idx];
  assign b_rd_tag   = tag_q[b_rd_idx];
  assign b_rd_entry = entry_q[b_rd_idx];

  // Next-state of the array: a write replaces the whole entry and marks it valid.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    entry_d = entry_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      entry_d[wr_idx] = wr_entry;
    end
  end

  // Valid bits are the only reset state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag and payload carry no reset; they are meaningless while valid is clear.
  always_ff @(posedge clk) begin
    tag_q   <= tag_d;
    entry_q <= entry_d;
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Fetch-stage BTB predictor driving RAS push/pop/checkpoint; optional stats via BTP_STATS_EN.
// Lookup is combinational (0 cycles fetch_pc -> pred_*/ras_*); training writes on the next edge.
// No backpressure: every lookup and update is accepted each cycle; flush only masks RAS controls.
module branch_target_predictor
  import btp_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_pc,
  input  logic [31:0] ras_pc,
  input  logic        ras_empty,
  output logic        ras_push,
  output logic [31:0] ras_new_entry,
  output logic        ras_pop,
  output logic        ras_checkpoint,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [1:0]  upd_type,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
`ifdef BTP_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_mispred
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag, f_rd_tag, u_rd_tag;
  logic             f_rd_valid, u_rd_valid;
  btb_entry_t       f_rd_entry, u_rd_entry, wr_entry;
  logic             wr_en, u_hit;
  logic [31:0]      fetch_pc_inc;
  logic [29:0]      pred_tgt;
  cf_type_e         u_type;

  // Word-offset bits carry no information for a 4-byte-aligned fetch.
  logic unused_bits;
  assign unused_bits = ^{fetch_pc[1:0], upd_pc[1:0], upd_target[1:0], ras_pc[1:0]};

  assign f_idx        = fetch_pc[IDX_W+1:2];
  assign f_tag        = fetch_pc[31:IDX_W+2];
  assign u_idx        = upd_pc[IDX_W+1:2];
  assign u_tag        = upd_pc[31:IDX_W+2];
  assign u_type       = cf_type_e'(upd_type);
  assign fetch_pc_inc = fetch_pc + 32'd4;

  btb_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_btb_table (
    .clk        (clk),
    .rst        (rst),
    .a_rd_idx   (f_idx),
    .a_rd_valid (f_rd_valid),
    .a_rd_tag   (f_rd_tag),
    .a_rd_entry (f_rd_entry),
    .b_rd_idx   (u_idx),
    .b_rd_valid (u_rd_valid),
    .b_rd_tag   (u_rd_tag),
    .b_rd_entry (u_rd_entry),
    .wr_en      (wr_en),
    .wr_idx     (u_idx),
    .wr_tag     (u_tag),
    .wr_entry   (wr_entry)
  );

  assign pred_hit = fetch_valid & f_rd_valid & (f_rd_tag == f_tag);

  // Direction and target select by stored type; a return prefers the live RAS top.
  always_comb begin
    pred_taken = 1'b0;
    pred_tgt   = f_rd_entry.target;
    if (pred_hit) begin
      if (f_rd_entry.typ == CF_BR) begin
        pred_taken = f_rd_entry.ctr[1];
      end else begin
        pred_taken = 1'b1;
        if (f_rd_entry.typ == CF_RET && !ras_empty) pred_tgt = ras_pc[31:2];
      end
    end
    pred_pc = pred_taken ? {pred_tgt, 2'b00} : fetch_pc_inc;
  end

  // RAS controls are mutually exclusive because each keys on a different stored type.
  always_comb begin
    ras_push       = pred_hit & (f_rd_entry.typ == CF_CALL) & ~flush;
    ras_pop        = pred_hit & (f_rd_entry.typ == CF_RET) & ~ras_empty & ~flush;
    ras_checkpoint = pred_hit & (f_rd_entry.typ == CF_BR) & ~flush;
    ras_new_entry  = ras_push ? fetch_pc_inc : 32'd0;
  end

  assign u_hit = upd_valid & u_rd_valid & (u_rd_tag == u_tag);

  // Training: refresh on a hit, allocate only on a taken miss.
  always_comb begin
    wr_en           = upd_valid & (u_hit | upd_taken);
    wr_entry.target = upd_target[31:2];
    wr_entry.typ    = u_type;
    if (u_type != CF_BR)  wr_entry.ctr = CTR_STRONG;
    else if (u_hit)       wr_entry.ctr = sat_ctr_next(u_rd_entry.ctr, upd_taken);
    else                  wr_entry.ctr = CTR_ALLOC_BR;
  end

`ifdef BTP_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;
  logic        u_mispred;

  // A misprediction is a BR direction disagreement on a hit, or any taken miss.
  always_comb begin
    if (u_hit) u_mispred = (u_type == CF_BR) & (u_rd_entry.ctr[1] != upd_taken);
    else       u_mispred = upd_valid & upd_taken;
    stat_lookups_d = stat_lookups_q + {31'd0, fetch_valid};
    stat_hits_d    = stat_hits_q + {31'd0, pred_hit};
    stat_mispred_d = stat_mispred_q + {31'd0, u_mispred};
  end

  // Free-running wrapping counters, cleared with the BTB valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups_q <= '0;
      stat_hits_q    <= '0;
      stat_mispred_q <= '0;
    end else begin
      stat_lookups_q <= stat_lookups_d;
      stat_hits_q    <= stat_hits_d;
      stat_mispred_q <= stat_mispred_d;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_hits    = stat_hits_q;
  assign stat_mispred = stat_mispred_q;
`endif

endmodule
